// File: rtl/scroll_sequencer.sv
// Frame sequencer: code FIFO, 3-cycle scroller load, 7-step scroll tick pass.
// Optional frame replay when starved: define SCROLL_SEQ_REPEAT_EN.
module scroll_sequencer #(
  parameter int          DEPTH    = 8,
  parameter int          TICK_DIV = 25_000_000,
  parameter logic [3:0]  BLANK    = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [3:0]               wr_data,
  input  logic                     rep_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     rd,
  output logic [3:0]               dec,
  output logic                     tick,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(TICK_DIV - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCROLL,
    DONE
`ifdef SCROLL_SEQ_REPEAT_EN
    , LOAD_REP
`endif
  } state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [DW-1:0]   div;
  logic [2:0]      step;

  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            push;
  logic            pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == LOAD);

`ifdef SCROLL_SEQ_REPEAT_EN
  logic [3:0] shadow [3];
`else
  logic unused_rep;
  assign unused_rep = rep_en;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr_en && full) ovf <= 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= '0;
      step       <= '0;
      rd         <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dec        <= BLANK;
`ifdef SCROLL_SEQ_REPEAT_EN
      for (int i = 0; i < 3; i++) shadow[i] <= BLANK;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (level >= LW'(3)) begin
            state <= LOAD;
            cnt   <= '0;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          dec <= mem[rptr];
`ifdef SCROLL_SEQ_REPEAT_EN
          shadow[cnt] <= mem[rptr];
`endif
          if (cnt == 2'd2) begin
            state <= SCROLL;
            rd    <= 1'b0;
            div   <= '0;
            step  <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
`ifdef SCROLL_SEQ_REPEAT_EN
        LOAD_REP: begin
          dec <= shadow[cnt];
          if (cnt == 2'd2) begin
            state <= SCROLL;
            rd    <= 1'b0;
            div   <= '0;
            step  <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
`endif
        SCROLL: begin
          dec  <= BLANK;
          // Registered tick lands in the cycle where div is DIV_LAST.
          tick <= (div == DIV_PRE);
          if (div == DIV_LAST) begin
            div <= '0;
            if (step == 3'd6) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              step <= step + 3'd1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
`ifdef SCROLL_SEQ_REPEAT_EN
          if (level < LW'(3) && rep_en) begin
            state <= LOAD_REP;
            cnt   <= '0;
            rd    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Randomized bench for scroll_sequencer against a frame-offset reference model.
// Honours SCROLL_SEQ_REPEAT_EN when the design is built with it.
module tb_scroll_sequencer;

  localparam int DEPTH = 8;
  localparam int TD    = 4;
  localparam logic [3:0] BLANK = 4'hF;
  localparam int FLEN  = 3 + 7 * TD + 1;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       rep_en;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       ovf;
  logic       rd;
  logic [3:0] dec;
  logic       tick;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mq [$];
  logic [3:0] mfc [3];
  int         mf;
  bit         m_rep;
  bit         m_ovf;

  scroll_sequencer #(
    .DEPTH(DEPTH),
    .TICK_DIV(TD),
    .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rep_en(rep_en),
    .full(full),
    .empty(empty),
    .level(level),
    .ovf(ovf),
    .rd(rd),
    .dec(dec),
    .tick(tick),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 3; i++) mfc[i] = BLANK;
    mf    = -1;
    m_rep = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Frame offset f: 0..2 load, 3..3+7*TD-1 scroll, 3+7*TD done, -1 idle.
  task automatic compare_all();
    int f;
    logic [3:0] ed;
    bit et;
    f  = mf;
    ed = BLANK;
    if (f >= 1 && f <= 3) ed = mfc[f-1];
    et = (f >= 3) && (f < 3 + 7 * TD) && (((f - 3) % TD) == TD - 1);
    check("rd", 32'(rd), 32'(f >= 0 && f <= 2));
    check("busy", 32'(busy), 32'(f >= 0));
    check("dec", 32'(dec), 32'(ed));
    check("tick", 32'(tick), 32'(et));
    check("frame_done", 32'(frame_done), 32'(f == FLEN - 1));
    check("level", 32'(level), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic model_step(input logic w, input logic [3:0] d,
                            input logic r);
    int sz;
    sz = mq.size();
    if (mf >= 0 && mf <= 2 && !m_rep) mfc[mf] = mq.pop_front();
    if (w) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    if (mf < 0) begin
      if (sz >= 3) begin
        mf    = 0;
        m_rep = 1'b0;
      end
    end else if (mf == FLEN - 1) begin
      mf = -1;
`ifdef SCROLL_SEQ_REPEAT_EN
      if (sz < 3 && r) begin
        mf    = 0;
        m_rep = 1'b1;
      end
`else
      if (r) mf = -1;
`endif
    end else begin
      mf++;
    end
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic w, input logic [3:0] d, input logic r);
    compare_all();
    wr_en   = w;
    wr_data = d;
    rep_en  = r;
    model_step(w, d, r);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, r);
  endtask

  task automatic mid_reset();
    #2;
    rst   = 1'b1;
    wr_en = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pct;
    int target;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 4'h0;
    rep_en  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0);
    idle(40, 1'b0);

    for (int i = 1; i <= 6; i++) cycle(1'b1, 4'(i), 1'b0);
    idle(80, 1'b0);

    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0);
    idle(6, 1'b0);
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 4'(i + 5), 1'b0);
    idle(150, 1'b0);

    for (int i = 0; i < 12; i++) cycle(1'b1, 4'(i), 1'b0);
    idle(150, 1'b0);

    for (int i = 10; i <= 12; i++) cycle(1'b1, 4'(i), 1'b0);
    target = 3 + 3 * TD + 1;
    for (int i = 0; i < 100 && mf != target; i++) cycle(1'b0, 4'h0, 1'b0);
    check("reach_step3", 32'(mf == target), 32'd1);
    mid_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i + 1), 1'b0);
    idle(40, 1'b0);

    for (int i = 7; i <= 9; i++) cycle(1'b1, 4'(i), 1'b0);
    idle(80, 1'b1);
    idle(40, 1'b0);

    pct = 30;
    for (int n = 0; n < 2000; n++) begin
      if (n % 200 == 0) pct = $urandom_range(0, 60);
      if (n == 1000) begin
        mid_reset();
      end else begin
        cycle(1'(($urandom_range(0, 99)) < pct), 4'($urandom),
              1'($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
